// File: rtl/load_store_unit.sv
//============================================================================
//  Module   : load_store_unit
//  Purpose  : Single-outstanding memory-access initiator between the execute
//             stage and a word-wide data memory. Issues word-aligned accesses,
//             extracts/extends sub-word load data and merges sub-word stores
//             through a read-modify-write sequence.
//  Ports    : clk, reset             - clock, synchronous active-high reset
//             req_i/we_i/funct3_i    - request strobe, store flag, RISC-V funct3
//             addr_i/wdata_i         - byte address, store data
//             busy_o/done_o/error_o  - stall, completion pulse, error flag
//             rdata_o                - load result (held until next good load)
//             Mem_Read_o/Mem_Write_o - memory strobes
//             Address_o/Write_Data_o - word address and write word
//             Read_Data_i            - combinational memory read data
//  Config   : LSU_SUBWORD_EN - when defined, byte/halfword accesses and the
//             RMW_RD/RMW_WR states are built; otherwise only LW/SW are legal.
//  Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  Mem_Write_o,
    output logic                  Mem_Read_o,
    output logic [DATA_WIDTH-1:0] Address_o,
    output logic [DATA_WIDTH-1:0] Write_Data_o,
    input  logic [DATA_WIDTH-1:0] Read_Data_i
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_RESP   = 3'd3
`ifdef LSU_SUBWORD_EN
        ,
        ST_RMW_RD = 3'd4,
        ST_RMW_WR = 3'd5
`endif
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [DATA_WIDTH-3:0]   r_word_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;
    logic                    w_f3_legal;
    logic                    w_misalign;
    logic                    w_req_err;
    logic [DATA_WIDTH-1:0]   w_load_data;

`ifdef LSU_SUBWORD_EN
    logic [1:0]              r_off;
    logic [2:0]              r_funct3;
    logic [DATA_WIDTH-1:0]   r_merge;
    logic [DATA_WIDTH-1:0]   w_lane;
    logic [DATA_WIDTH-1:0]   w_merged;
`endif

    // Request decode: legality of funct3 and natural alignment of the access.
`ifdef LSU_SUBWORD_EN
    always_comb begin
        if (we_i) begin
            w_f3_legal = funct3_i inside {3'b000, 3'b001, 3'b010};
        end else begin
            w_f3_legal = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        w_misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    end
`else
    always_comb begin
        w_f3_legal = (funct3_i == 3'b010);
        w_misalign = (addr_i[1:0] != 2'b00);
    end
`endif

    assign w_req_err = !w_f3_legal || w_misalign;

`ifdef LSU_SUBWORD_EN
    // Shift the addressed lane down to bit 0, then extend per funct3[2]
    // (set = unsigned variant).
    assign w_lane = Read_Data_i >> {r_off, 3'b000};

    always_comb begin
        w_load_data = Read_Data_i;
        case (r_funct3[1:0])
            2'b00:   w_load_data = {{(DATA_WIDTH-8){~r_funct3[2] & w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_load_data = {{(DATA_WIDTH-16){~r_funct3[2] & w_lane[15]}}, w_lane[15:0]};
            default: w_load_data = Read_Data_i;
        endcase
    end

    // Replace only the addressed byte/halfword of the word read in RMW_RD.
    always_comb begin
        w_merged = r_merge;
        if (r_funct3[1:0] == 2'b00) begin
            w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end
`else
    assign w_load_data = Read_Data_i;
`endif

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_i) begin
                    if (w_req_err) begin
                        w_next = ST_RESP;
                    end else if (!we_i) begin
                        w_next = ST_LOAD;
`ifdef LSU_SUBWORD_EN
                    end else if (funct3_i[1:0] != 2'b10) begin
                        w_next = ST_RMW_RD;
`endif
                    end else begin
                        w_next = ST_STORE;
                    end
                end
            end
            ST_LOAD:   w_next = ST_RESP;
            ST_STORE:  w_next = ST_RESP;
`ifdef LSU_SUBWORD_EN
            ST_RMW_RD: w_next = ST_RMW_WR;
            ST_RMW_WR: w_next = ST_RESP;
`endif
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Output decode. Memory strobes are gated by reset so an access caught
    // mid-flight by reset never reaches the memory.
    always_comb begin
        busy_o       = (r_state != ST_IDLE);
        done_o       = (r_state == ST_RESP);
        error_o      = (r_state == ST_RESP) && r_err;
        Mem_Read_o   = 1'b0;
        Mem_Write_o  = 1'b0;
        Address_o    = '0;
        Write_Data_o = '0;
        case (r_state)
            ST_LOAD: begin
                Mem_Read_o = !reset;
                Address_o  = {r_word_addr, 2'b00};
            end
            ST_STORE: begin
                Mem_Write_o  = !reset;
                Address_o    = {r_word_addr, 2'b00};
                Write_Data_o = r_wdata;
            end
`ifdef LSU_SUBWORD_EN
            ST_RMW_RD: begin
                Mem_Read_o = !reset;
                Address_o  = {r_word_addr, 2'b00};
            end
            ST_RMW_WR: begin
                Mem_Write_o  = !reset;
                Address_o    = {r_word_addr, 2'b00};
                Write_Data_o = w_merged;
            end
`endif
            default: begin
                Mem_Read_o = 1'b0;
            end
        endcase
    end

    assign rdata_o = r_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_word_addr <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
`ifdef LSU_SUBWORD_EN
            r_off       <= 2'b00;
            r_funct3    <= 3'b000;
            r_merge     <= '0;
`endif
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && req_i) begin
                r_word_addr <= addr_i[DATA_WIDTH-1:2];
                r_wdata     <= wdata_i;
                r_err       <= w_req_err;
`ifdef LSU_SUBWORD_EN
                r_off       <= addr_i[1:0];
                r_funct3    <= funct3_i;
`endif
            end
            if (r_state == ST_LOAD) begin
                r_rdata <= w_load_data;
            end
`ifdef LSU_SUBWORD_EN
            if (r_state == ST_RMW_RD) begin
                r_merge <= Read_Data_i;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Scoreboard bench for load_store_unit. A small word memory sits
//             on the memory port; a reference model predicts each response.
//  Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_load_store_unit;

    localparam logic [31:0] c_BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        busy_o, done_o, error_o, Mem_Write_o, Mem_Read_o;
    logic [31:0] rdata_o, Address_o, Write_Data_o, Read_Data_i;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_i        (req_i),
        .we_i         (we_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .rdata_o      (rdata_o),
        .Mem_Write_o  (Mem_Write_o),
        .Mem_Read_o   (Mem_Read_o),
        .Address_o    (Address_o),
        .Write_Data_o (Write_Data_o),
        .Read_Data_i  (Read_Data_i)
    );

    always #5 clk = ~clk;

    // Eight-word memory covering c_BASE .. c_BASE+31
    logic [31:0] mem     [8];
    logic [31:0] ref_mem [8];
    assign Read_Data_i = mem[Address_o[4:2]];
    always @(posedge clk) begin
        if (Mem_Write_o) mem[Address_o[4:2]] <= Write_Data_o;
    end

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] waddr;
        logic [31:0] wword;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          issued = 0;
    int          completed = 0;
    logic [31:0] model_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic finish_sim();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // Reference model: works from byte offsets and access sizes directly.
    task automatic predict(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output exp_t e);
        int          idx, off, nbytes;
        bit          legal;
        logic [31:0] w;
        idx    = int'(a[4:2]);
        off    = int'(a[1:0]);
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
`ifdef LSU_SUBWORD_EN
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`else
        legal = (f3 == 3'd2);
`endif
        if ((off % nbytes) != 0) legal = 1'b0;
        e.err   = !legal;
        e.lat   = 1;
        e.nrd   = 0;
        e.nwr   = 0;
        e.waddr = {a[31:2], 2'b00};
        e.wword = 32'h0;
        if (legal && !we) begin
            e.lat = 2;
            e.nrd = 1;
            w = ref_mem[idx] >> (8 * off);
            if (nbytes == 1)
                w = (!f3[2] && w[7]) ? (w | 32'hFFFF_FF00) : (w & 32'h0000_00FF);
            else if (nbytes == 2)
                w = (!f3[2] && w[15]) ? (w | 32'hFFFF_0000) : (w & 32'h0000_FFFF);
            model_rdata = w;
        end else if (legal) begin
            w = ref_mem[idx];
            for (int k = 0; k < nbytes; k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
            e.lat   = (nbytes == 4) ? 2 : 3;
            e.nrd   = (nbytes == 4) ? 0 : 1;
            e.nwr   = 1;
            e.wword = w;
            ref_mem[idx] = w;
        end
        e.rdata = model_rdata;
    endtask

    // Driver: called at posedge+1; returns at posedge+1 after completion.
    // Inputs are scrambled while busy since the DUT must ignore them.
    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        exp_t e;
        bit   ok;
        predict(we, f3, a, wd, e);
        exp_q.push_back(e);
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        issued++;
        req_i = 1'($urandom); we_i = 1'($urandom); funct3_i = 3'($urandom);
        addr_i = $urandom; wdata_i = $urandom;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (issued == completed) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("completion_timeout", 32'd1, 32'd0);
            finish_sim();
        end
        #1;
        req_i = 1'b0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        exp_t e;
        int   nrd_seen, nwr_seen;
        if (!reset) begin
            check("busy_o", 32'(busy_o), 32'(issued != completed));
            if (issued == completed) begin
                check("idle_strobes", {29'd0, Mem_Read_o, Mem_Write_o, done_o}, 32'd0);
            end else if (exp_q.size() > 0) begin
                if (Mem_Read_o || Mem_Write_o) check("Address_o", Address_o, exp_q[0].waddr);
                if (Mem_Read_o) nrd_seen++;
                if (Mem_Write_o) begin
                    nwr_seen++;
                    check("Write_Data_o", Write_Data_o, exp_q[0].wword);
                end
                if (done_o) begin
                    e = exp_q.pop_front();
                    check("error_o", 32'(error_o), 32'(e.err));
                    check("rdata_o", rdata_o, e.rdata);
                    check("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
                    check("read_cycles", 32'(nrd_seen), 32'(e.nrd));
                    check("write_cycles", 32'(nwr_seen), 32'(e.nwr));
                    nrd_seen = 0;
                    nwr_seen = 0;
                    completed++;
                end
            end
        end else begin
            nrd_seen = 0;
            nwr_seen = 0;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy_o), 32'd0);
        check({tag, "_done"},  32'(done_o), 32'd0);
        check({tag, "_error"}, 32'(error_o), 32'd0);
        check({tag, "_rdata"}, rdata_o, 32'd0);
        check({tag, "_strobes"}, {30'd0, Mem_Read_o, Mem_Write_o}, 32'd0);
        check({tag, "_addr"},  Address_o, 32'd0);
        check({tag, "_wdata"}, Write_Data_o, 32'd0);
    endtask

    initial begin : stim
        bit          we;
        logic [2:0]  f3;
        logic [31:0] a, old;
        int          n;

        for (int i = 0; i < 8; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[1]     = 32'h8899_AABB;
        ref_mem[1] = 32'h8899_AABB;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;

`ifdef LSU_SUBWORD_EN
        issue(1'b0, 3'b000, c_BASE + 32'd5, 32'h0);
        check("LB_const", rdata_o, 32'hFFFF_FFAA);
        issue(1'b0, 3'b100, c_BASE + 32'd5, 32'h0);
        check("LBU_const", rdata_o, 32'h0000_00AA);
        issue(1'b0, 3'b101, c_BASE + 32'd6, 32'h0);
        check("LHU_const", rdata_o, 32'h0000_8899);
        issue(1'b0, 3'b010, c_BASE + 32'd4, 32'h0);
        check("LW_const", rdata_o, 32'h8899_AABB);
        issue(1'b1, 3'b000, c_BASE + 32'd6, 32'h0000_0011);
        check("SB_const", mem[1], 32'h8811_AABB);
        issue(1'b0, 3'b001, c_BASE + 32'd3, 32'h0);
        check("LH_misaligned_rdata", rdata_o, 32'h8899_AABB);
`else
        issue(1'b1, 3'b000, c_BASE + 32'd4, 32'h0000_0011);
        check("SB_disabled_mem", mem[1], 32'h8899_AABB);
        issue(1'b1, 3'b010, c_BASE + 32'd4, 32'h1234_5678);
        check("SW_const", mem[1], 32'h1234_5678);
        issue(1'b0, 3'b010, c_BASE + 32'd4, 32'h0);
        check("LW_const", rdata_o, 32'h1234_5678);
`endif

        repeat (300) begin
            we = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
`ifdef LSU_SUBWORD_EN
                f3 = 3'($urandom_range(0, 2));
                if (!we && f3 != 3'd2 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
`else
                f3 = 3'd2;
`endif
            end else begin
                f3 = 3'($urandom);
            end
            a = c_BASE + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            issue(we, f3, a, $urandom);
            n = $urandom_range(0, 2);
            if (n > 0) begin
                repeat (n) @(posedge clk);
                #1;
            end
        end

        // Reset during the first access cycle of a store: no write may occur.
        old = mem[1];
`ifdef LSU_SUBWORD_EN
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b001; addr_i = c_BASE + 32'd4; wdata_i = 32'hDEAD_BEEF;
`else
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b010; addr_i = c_BASE + 32'd4; wdata_i = 32'hDEAD_BEEF;
`endif
        @(posedge clk);
        #1;
        req_i = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("reset_abort_strobes", {30'd0, Mem_Read_o, Mem_Write_o}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_rdata = 32'h0;
        @(negedge clk);
        check_all_zero("abort");
        check("abort_mem", mem[1], old);

        // Reset and request together: the request is dropped.
        @(posedge clk);
        #1;
        reset = 1'b1;
        req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = c_BASE;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_i = 1'b0;
        @(negedge clk);
        check_all_zero("reset_req");
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) check("final_mem", mem[i], ref_mem[i]);
        check("pending_expectations", 32'(exp_q.size()), 32'd0);
        finish_sim();
    end

    initial begin : watchdog
        #2000000;
        check("global_timeout", 32'd1, 32'd0);
        finish_sim();
    end

endmodule

`default_nettype wire
